wb_master_bridge: RTL and testbench
===================================

// Module: wb_master_bridge
// PURPOSE
//  Parametrised, stalling Wishbone classic master between the core's memory stage and the SoC interconnect.
//  Registers each processor load/store and holds the bus cycle until ACK, stalling the pipeline meanwhile.
//  Byte-lane alignment covers 32- and 64-bit buses. Misaligned accesses are rejected without a bus cycle.
//  Optional ACK timeout.
// PARAMETERS
//  DATA_W       32   bus/processor data width; legal values 32, 64
//  ADDR_W       32   address width
//  SEL_W        DATA_W/8  byte-enable width (derived, not overridable)
//  TIMEOUT_CYC  255  cycles in BUS without ACK before abort (only with WB_TIMEOUT_EN)
// PORTS
//  clk          in   1       clock; all state on rising edge
//  reset_n      in   1       asynchronous active-low reset
//  proc_addr    in   ADDR_W  byte address
//  proc_wdata   in   DATA_W  store data, right-justified
//  proc_write   in   1       store request (level, held until proc_stall=0)
//  proc_read    in   1       load request (level, held until proc_stall=0)
//  proc_op      in   3       funct3: 000 B, 001 H, 010 W, 011 D (DATA_W=64 only), 100 BU, 101 HU, 110 WU (64 only)
//  proc_rdata   out  DATA_W  aligned, sign/zero-extended load data
//  proc_stall   out  1       hold pipeline
//  proc_err     out  1       1-cycle pulse: misaligned / illegal op / timeout
//  wb_adr_o     out  ADDR_W  address, low log2(SEL_W) bits forced 0
//  wb_dat_o     out  DATA_W  lane-shifted store data
//  wb_sel_o     out  SEL_W   byte enables
//  wb_we_o      out  1       write enable
//  wb_cyc_o     out  1       cycle
//  wb_stb_o     out  1       strobe
//  wb_dat_i     in   DATA_W  read data
//  wb_ack_i     in   1       acknowledge
// BEHAVIOUR
//  Reset: state IDLE; all wb_* outputs, proc_rdata, proc_err = 0. Async reset mid-cycle drops cyc/stb immediately.
//  proc_stall (comb) = (IDLE & (proc_read|proc_write)) | BUS. It is 0 in DONE.
//  FSM IDLE->BUS: on request, latch addr/op/we, aligned wdata and sel. wb_* outputs are registered from latched values.
//  FSM IDLE->DONE: on misaligned access (H: a[0]!=0; W: a[1:0]!=0; D: a[2:0]!=0) or illegal op. proc_err=1, no bus cycle.
//  FSM BUS: cyc=stb=1; we/adr/dat/sel stable. On wb_ack_i: capture load-aligned wb_dat_i (reads only), go DONE. cyc/stb=0 next cycle.
//  FSM DONE->IDLE: single cycle; proc_stall=0 so the core advances. The still-present old request is NOT re-accepted.
//  Minimum latency: 3 cycles request->DONE (ack in first BUS cycle). Back-to-back throughput: 1 access / 3 cycles.
//  proc_write & proc_read together: treated as write; read ignored.
//  wb_ack_i outside BUS: ignored.
//  proc_rdata holds its value until the next successful read. Writes and errors leave it unchanged, except timeout.
//  Store lanes: sel = {B:1,H:3,W:F,D:FF} << a[low]; wdata replicated/shifted into the selected lanes.
//  Load: select lane by latched a[low], then sign-extend (B,H,W) or zero-extend (BU,HU,WU) to DATA_W.
// CONFIGURATION
//  WB_TIMEOUT_EN defined:
//    8-bit min counter clears on BUS entry and increments each BUS cycle.
//    At TIMEOUT_CYC without ack: drop cyc/stb, go DONE with proc_err=1, proc_rdata = all ones (reads).
//  WB_TIMEOUT_EN undefined: no counter; BUS waits indefinitely for ACK.
// STRUCTURE
//  wb_pkg: mem_op_t enum (funct3 codes above), wb_state_t {IDLE,BUS,DONE}, lane_sel function.
//  Sub-module wb_lane_aligner (combinational, parametrised DATA_W): store shift/sel and load extract/extend.
//  Instantiated once for the store path and once for the load path.
// TESTING
//  1 SW a=0x104, wdata=0xDEADBEEF, ack after 2 cycles -> sel=F, dat_o=DEADBEEF; stall 4 cycles; cyc low in DONE.
//  2 LB a=0x103, wb_dat_i=0x80FF_0000 (32b) -> proc_rdata=0xFFFFFF80. LBU same -> 0x00000080.
//  3 SH a=0x102, wdata=0x1234 -> sel=4'b1100, dat_o=0x12340000. LH a=0x101 -> proc_err pulse, cyc never asserted.
//  4 DATA_W=64: SD a=0x8 -> sel=FF. LW a=0xC, wb_dat_i=0x8000_0000_xxxx -> proc_rdata sign-extended 0xFFFFFFFF80000000.
//  5 reset_n low during BUS -> cyc/stb/stall fall same cycle. Next request after release completes normally.
//  6 WB_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> abort after 4 BUS cycles, proc_err=1, rdata=all ones. Late ack ignored.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone classic master bridge.
// Op encodings follow the core's funct3 load/store field.
package wb_pkg;

    typedef enum logic [2:0] {
        OP_B  = 3'b000,
        OP_H  = 3'b001,
        OP_W  = 3'b010,
        OP_D  = 3'b011,
        OP_BU = 3'b100,
        OP_HU = 3'b101,
        OP_WU = 3'b110
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } wb_state_t;

    // Byte-enable pattern for an access of size op at byte offset lo (8-lane view).
    function automatic logic [7:0] lane_sel(input mem_op_t op, input logic [2:0] lo);
        logic [7:0] base;
        case (op)
            OP_B, OP_BU: base = 8'h01;
            OP_H, OP_HU: base = 8'h03;
            OP_W, OP_WU: base = 8'h0F;
            OP_D:        base = 8'hFF;
            default:     base = 8'h00;
        endcase
        return base << lo;
    endfunction

    function automatic logic misaligned(input mem_op_t op, input logic [2:0] lo);
        case (op)
            OP_H, OP_HU: return lo[0];
            OP_W, OP_WU: return |lo[1:0];
            OP_D:        return |lo;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic op_legal(input mem_op_t op, input int unsigned data_w);
        case (op)
            OP_B, OP_H, OP_W, OP_BU, OP_HU: return 1'b1;
            OP_D, OP_WU:                    return data_w == 64;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_lane_aligner.sv
// Combinational byte-lane aligner: LOAD=0 shifts store data into its lanes,
// LOAD=1 extracts the addressed lane and sign/zero-extends it.
module wb_lane_aligner
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter bit          LOAD   = 1'b0,
    localparam int unsigned LO_W  = $clog2(DATA_W / 8)
) (
    input  mem_op_t             op,
    input  logic [LO_W-1:0]     lo,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out
);

    logic [LO_W+2:0] shamt;
    assign shamt = {lo, 3'b000};

    if (LOAD) begin : g_load
        logic [DATA_W-1:0] lane;
        assign lane = data_in >> shamt;

        always_comb begin
            data_out = '0;
            case (op)
                OP_B:    data_out = DATA_W'($signed(lane[7:0]));
                OP_BU:   data_out = DATA_W'(lane[7:0]);
                OP_H:    data_out = DATA_W'($signed(lane[15:0]));
                OP_HU:   data_out = DATA_W'(lane[15:0]);
                OP_W:    data_out = DATA_W'($signed(lane[31:0]));
                OP_WU:   data_out = DATA_W'(lane[31:0]);
                OP_D:    data_out = lane;
                default: data_out = '0;
            endcase
        end
    end else begin : g_store
        logic [DATA_W-1:0] mask;

        always_comb begin
            mask = '0;
            case (op)
                OP_B, OP_BU: mask = DATA_W'(8'hFF);
                OP_H, OP_HU: mask = DATA_W'(16'hFFFF);
                OP_W, OP_WU: mask = DATA_W'(32'hFFFF_FFFF);
                OP_D:        mask = '1;
                default:     mask = '0;
            endcase
        end

        assign data_out = (data_in & mask) << shamt;
    end

endmodule

// File: rtl/wb_master_bridge.sv
// Stalling Wishbone classic master for the memory stage; one access per bus cycle.
// Define WB_TIMEOUT_EN to abort a bus cycle after TIMEOUT_CYC cycles without ACK.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255,
    localparam int unsigned SEL_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [DATA_W-1:0] proc_wdata,
    input  logic              proc_write,
    input  logic              proc_read,
    input  logic [2:0]        proc_op,
    output logic [DATA_W-1:0] proc_rdata,
    output logic              proc_stall,
    output logic              proc_err,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i
);

    localparam int unsigned LO_W = $clog2(SEL_W);

    if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_width
        $error("wb_master_bridge: DATA_W must be 32 or 64");
    end
    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("wb_master_bridge: TIMEOUT_CYC must be non-zero");
    end

    wb_state_t         state, state_next;
    mem_op_t           req_op, lat_op;
    logic [LO_W-1:0]   lat_lo;
    logic [2:0]        req_lo3;
    logic              req, req_bad, accept, reject, bus_ack, tmo_hit;
    logic [SEL_W-1:0]  req_sel;
    logic [DATA_W-1:0] st_data, ld_data;

    assign req_op  = mem_op_t'(proc_op);
    assign req     = proc_read | proc_write;
    assign req_lo3 = 3'(proc_addr[LO_W-1:0]);
    assign req_bad = misaligned(req_op, req_lo3) | ~op_legal(req_op, DATA_W);
    assign req_sel = SEL_W'(lane_sel(req_op, req_lo3));
    assign accept  = (state == IDLE) & req & ~req_bad;
    assign reject  = (state == IDLE) & req & req_bad;
    assign bus_ack = (state == BUS) & wb_ack_i;

    // Gated by reset_n so the pipeline is released as soon as reset asserts.
    assign proc_stall = reset_n & (((state == IDLE) & req) | (state == BUS));

    wb_lane_aligner #(.DATA_W(DATA_W), .LOAD(1'b0)) u_store (
        .op       (req_op),
        .lo       (proc_addr[LO_W-1:0]),
        .data_in  (proc_wdata),
        .data_out (st_data)
    );

    wb_lane_aligner #(.DATA_W(DATA_W), .LOAD(1'b1)) u_load (
        .op       (lat_op),
        .lo       (lat_lo),
        .data_in  (wb_dat_i),
        .data_out (ld_data)
    );

`ifdef WB_TIMEOUT_EN
    localparam int unsigned TMO_W =
        ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == BUS) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign tmo_hit = (state == BUS) & ~wb_ack_i & (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (reject) begin
                    state_next = DONE;
                end else if (accept) begin
                    state_next = BUS;
                end
            end
            BUS: begin
                if (bus_ack || tmo_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            proc_rdata <= '0;
            proc_err   <= 1'b0;
            lat_op     <= OP_B;
            lat_lo     <= '0;
        end else begin
            proc_err <= reject;
            if (accept) begin
                wb_adr_o <= {proc_addr[ADDR_W-1:LO_W], {LO_W{1'b0}}};
                wb_dat_o <= proc_write ? st_data : '0;
                wb_sel_o <= req_sel;
                wb_we_o  <= proc_write;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                lat_op   <= req_op;
                lat_lo   <= proc_addr[LO_W-1:0];
            end
            if (bus_ack) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                if (!wb_we_o) begin
                    proc_rdata <= ld_data;
                end
            end else if (tmo_hit) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                proc_err <= 1'b1;
                if (!wb_we_o) begin
                    proc_rdata <= '1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Scoreboard bench for wb_master_bridge: 32-bit and 64-bit instances share one
// stimulus driver, a Wishbone slave model, and response/bus monitors.
module tb_wb_master_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        use64;
    logic [31:0] addr;
    logic [63:0] wdata, dat_i;
    logic [2:0]  op;
    logic        rd, wr, ack;

    always #5 clk = ~clk;

    logic [31:0] r32, dat32, adr32, adr64;
    logic [3:0]  sel32;
    logic [63:0] r64, dat64;
    logic [7:0]  sel64;
    logic        stall32, err32, we32, cyc32, stb32;
    logic        stall64, err64, we64, cyc64, stb64;

    wb_master_bridge #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(4)) u_dut32 (
        .clk(clk), .reset_n(reset_n),
        .proc_addr(addr), .proc_wdata(wdata[31:0]),
        .proc_write(wr & ~use64), .proc_read(rd & ~use64), .proc_op(op),
        .proc_rdata(r32), .proc_stall(stall32), .proc_err(err32),
        .wb_adr_o(adr32), .wb_dat_o(dat32), .wb_sel_o(sel32), .wb_we_o(we32),
        .wb_cyc_o(cyc32), .wb_stb_o(stb32),
        .wb_dat_i(dat_i[31:0]), .wb_ack_i(ack & ~use64)
    );

    wb_master_bridge #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(4)) u_dut64 (
        .clk(clk), .reset_n(reset_n),
        .proc_addr(addr), .proc_wdata(wdata),
        .proc_write(wr & use64), .proc_read(rd & use64), .proc_op(op),
        .proc_rdata(r64), .proc_stall(stall64), .proc_err(err64),
        .wb_adr_o(adr64), .wb_dat_o(dat64), .wb_sel_o(sel64), .wb_we_o(we64),
        .wb_cyc_o(cyc64), .wb_stb_o(stb64),
        .wb_dat_i(dat_i), .wb_ack_i(ack & use64)
    );

    logic [63:0] m_rdata, m_dat;
    logic [31:0] m_adr;
    logic [7:0]  m_sel;
    logic        m_stall, m_err, m_we, m_cyc, m_stb;

    assign m_rdata = use64 ? r64 : {32'h0, r32};
    assign m_dat   = use64 ? dat64 : {32'h0, dat32};
    assign m_adr   = use64 ? adr64 : adr32;
    assign m_sel   = use64 ? sel64 : {4'h0, sel32};
    assign m_stall = use64 ? stall64 : stall32;
    assign m_err   = use64 ? err64 : err32;
    assign m_we    = use64 ? we64 : we32;
    assign m_cyc   = use64 ? cyc64 : cyc32;
    assign m_stb   = use64 ? stb64 : stb32;

    typedef struct {
        int          id;
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        int          id;
        logic [31:0] adr;
        logic [7:0]  sel;
        logic [63:0] dat;
        logic        we;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    tid     = 0;

    int          ack_delay = 0;
    logic [63:0] slave_data = '0;
    bit          late_ack = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave: ACK after ack_delay extra BUS cycles; late_ack forces one stray ACK.
    initial begin : slave
        int wcnt;
        bit fired;
        ack = 1'b0;
        dat_i = '0;
        wcnt = 0;
        fired = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (m_cyc && !fired) begin
                if (wcnt == ack_delay) begin
                    ack = 1'b1;
                    dat_i = slave_data;
                    fired = 1'b1;
                end else begin
                    ack = 1'b0;
                    wcnt++;
                end
            end else begin
                ack = late_ack;
                late_ack = 1'b0;
                if (!m_cyc) begin
                    wcnt = 0;
                    fired = 1'b0;
                end
            end
        end
    end

    resp_t r_exp;
    bus_t  b_exp;
    bit    cyc_seen = 1'b0;

    always @(negedge clk) begin
        if (reset_n && (rd || wr) && !m_stall) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_completion", 64'h1, 64'h0);
            end else begin
                r_exp = resp_q.pop_front();
                chk($sformatf("rdata#%0d", r_exp.id), m_rdata, r_exp.rdata);
                chk($sformatf("err#%0d", r_exp.id), 64'(m_err), 64'(r_exp.err));
                chk($sformatf("cyc_in_done#%0d", r_exp.id), 64'(m_cyc), 64'h0);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && m_cyc && !cyc_seen) begin
            cyc_seen = 1'b1;
            if (bus_q.size() == 0) begin
                chk("unexpected_bus_cycle", 64'(m_cyc), 64'h0);
            end else begin
                b_exp = bus_q.pop_front();
                chk($sformatf("adr#%0d", b_exp.id), 64'(m_adr), 64'(b_exp.adr));
                chk($sformatf("sel#%0d", b_exp.id), 64'(m_sel), 64'(b_exp.sel));
                chk($sformatf("dat#%0d", b_exp.id), m_dat, b_exp.dat);
                chk($sformatf("we#%0d", b_exp.id), 64'(m_we), 64'(b_exp.we));
                chk($sformatf("stb#%0d", b_exp.id), 64'(m_stb), 64'h1);
            end
        end
        if (!m_cyc) cyc_seen = 1'b0;
    end

    task automatic txn(input bit w64, input bit we_i, input bit rd_i, input logic [2:0] op_i,
                       input logic [31:0] a, input logic [63:0] wd, input int dly,
                       input logic [63:0] bdat, input logic [63:0] exp_r, input bit exp_e,
                       input bit exp_bus, input logic [31:0] exp_adr, input logic [7:0] exp_sel,
                       input logic [63:0] exp_dat, input int exp_stall);
        int  stalls;
        bit  done;
        @(posedge clk);
        #1;
        use64 = w64;
        addr = a;
        wdata = wd;
        op = op_i;
        ack_delay = dly;
        slave_data = bdat;
        tid++;
        resp_q.push_back('{id: tid, rdata: exp_r, err: exp_e});
        if (exp_bus) bus_q.push_back('{id: tid, adr: exp_adr, sel: exp_sel, dat: exp_dat, we: we_i});
        wr = we_i;
        rd = rd_i;
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (m_stall) stalls++;
            else done = 1'b1;
        end
        if (!done) chk($sformatf("stall_release#%0d", tid), 64'h0, 64'h1);
        if (exp_stall >= 0) chk($sformatf("stall_cycles#%0d", tid), 64'(stalls), 64'(exp_stall));
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset_n = 1'b0;
        use64 = 1'b0;
        addr = '0;
        wdata = '0;
        op = 3'b000;
        rd = 1'b0;
        wr = 1'b0;
        #1;
        chk("rst_rdata32", {32'h0, r32}, 64'h0);
        chk("rst_rdata64", r64, 64'h0);
        chk("rst_cyc_stb", {62'h0, cyc32 | cyc64, stb32 | stb64}, 64'h0);
        chk("rst_err", {63'h0, err32 | err64}, 64'h0);
        chk("rst_sel_adr", {sel64, sel32, adr32}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // 32-bit: w64 we rd op addr wdata dly bus_data exp_rdata err bus adr sel dat stall
        txn(0, 1, 0, 3'b010, 32'h104, 64'hDEADBEEF, 2, 64'h0, 64'h0, 0, 1, 32'h104, 8'h0F, 64'hDEADBEEF, 4);
        txn(0, 0, 1, 3'b000, 32'h103, 64'h0, 0, 64'h80FF0000, 64'hFFFFFF80, 0, 1, 32'h100, 8'h08, 64'h0, 2);
        txn(0, 0, 1, 3'b100, 32'h103, 64'h0, 0, 64'h80FF0000, 64'h00000080, 0, 1, 32'h100, 8'h08, 64'h0, 2);
        txn(0, 1, 0, 3'b001, 32'h102, 64'h1234, 1, 64'h0, 64'h00000080, 0, 1, 32'h100, 8'h0C, 64'h12340000, 3);
        txn(0, 0, 1, 3'b001, 32'h101, 64'h0, 0, 64'h0, 64'h00000080, 1, 0, 32'h0, 8'h0, 64'h0, 1);
        txn(0, 0, 1, 3'b010, 32'h200, 64'h0, 0, 64'h12345678, 64'h12345678, 0, 1, 32'h200, 8'h0F, 64'h0, 2);
        txn(0, 0, 1, 3'b101, 32'h102, 64'h0, 0, 64'hBEEF0000, 64'h0000BEEF, 0, 1, 32'h100, 8'h0C, 64'h0, 2);
        txn(0, 0, 1, 3'b001, 32'h100, 64'h0, 0, 64'h00008001, 64'hFFFF8001, 0, 1, 32'h100, 8'h03, 64'h0, 2);
        txn(0, 0, 1, 3'b011, 32'h000, 64'h0, 0, 64'h0, 64'hFFFF8001, 1, 0, 32'h0, 8'h0, 64'h0, 1);
        txn(0, 0, 1, 3'b111, 32'h000, 64'h0, 0, 64'h0, 64'hFFFF8001, 1, 0, 32'h0, 8'h0, 64'h0, 1);
        txn(0, 1, 0, 3'b010, 32'h102, 64'h0, 0, 64'h0, 64'hFFFF8001, 1, 0, 32'h0, 8'h0, 64'h0, 1);
        txn(0, 1, 1, 3'b010, 32'h300, 64'h55AA55AA, 0, 64'h11111111, 64'hFFFF8001, 0, 1, 32'h300, 8'h0F, 64'h55AA55AA, 2);
        txn(0, 1, 0, 3'b000, 32'h101, 64'hAB, 0, 64'h0, 64'hFFFF8001, 0, 1, 32'h100, 8'h02, 64'h0000AB00, 2);
        txn(0, 0, 1, 3'b110, 32'h000, 64'h0, 0, 64'h0, 64'hFFFF8001, 1, 0, 32'h0, 8'h0, 64'h0, 1);

        // 64-bit bus
        txn(1, 1, 0, 3'b011, 32'h8, 64'h0123456789ABCDEF, 0, 64'h0, 64'h0, 0, 1, 32'h8, 8'hFF, 64'h0123456789ABCDEF, 2);
        txn(1, 0, 1, 3'b010, 32'hC, 64'h0, 0, 64'h8000000000001234, 64'hFFFFFFFF80000000, 0, 1, 32'h8, 8'hF0, 64'h0, 2);
        txn(1, 0, 1, 3'b110, 32'hC, 64'h0, 0, 64'h8000000000001234, 64'h0000000080000000, 0, 1, 32'h8, 8'hF0, 64'h0, 2);
        txn(1, 0, 1, 3'b011, 32'h4, 64'h0, 0, 64'h0, 64'h0000000080000000, 1, 0, 32'h0, 8'h0, 64'h0, 1);
        txn(1, 1, 0, 3'b010, 32'hC, 64'hCAFEF00D, 0, 64'h0, 64'h0000000080000000, 0, 1, 32'h8, 8'hF0, 64'hCAFEF00D00000000, 2);
        txn(1, 0, 1, 3'b000, 32'hF, 64'h0, 1, 64'h7F00000000000000, 64'h000000000000007F, 0, 1, 32'h8, 8'h80, 64'h0, 3);

        // Asynchronous reset while the bus cycle is open
        @(posedge clk);
        #1;
        use64 = 1'b0;
        addr = 32'h180;
        op = 3'b010;
        ack_delay = 255;
        tid++;
        bus_q.push_back('{id: tid, adr: 32'h180, sel: 8'h0F, dat: 64'h0, we: 1'b0});
        rd = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = m_cyc;
        end
        chk("reset_test_cyc_seen", 64'(seen), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_cyc", 64'(m_cyc), 64'h0);
        chk("async_rst_stb", 64'(m_stb), 64'h0);
        chk("async_rst_stall", 64'(m_stall), 64'h0);
        rd = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        txn(0, 0, 1, 3'b010, 32'h204, 64'h0, 0, 64'hA5A5A5A5, 64'hA5A5A5A5, 0, 1, 32'h204, 8'h0F, 64'h0, 2);

`ifdef WB_TIMEOUT_EN
        txn(0, 0, 1, 3'b010, 32'h40, 64'h0, 255, 64'h0, 64'hFFFFFFFF, 1, 1, 32'h40, 8'h0F, 64'h0, 5);
        late_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("late_ack_rdata", m_rdata, 64'hFFFFFFFF);
        chk("late_ack_cyc", 64'(m_cyc), 64'h0);
        chk("late_ack_err", 64'(m_err), 64'h0);
        txn(0, 0, 1, 3'b100, 32'h41, 64'h0, 0, 64'h00005A00, 64'h0000005A, 0, 1, 32'h40, 8'h02, 64'h0, 2);
`endif

        repeat (3) @(posedge clk);
        chk("resp_q_drained", 64'(resp_q.size()), 64'h0);
        chk("bus_q_drained", 64'(bus_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
